// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FSM encoding, oversampling ratio and the host
// command bytes understood by the debug unit.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CMD_START        = 8'h01;
  localparam logic [7:0] CMD_CONTINUOUS   = 8'h02;
  localparam logic [7:0] CMD_STEP_BY_STEP = 8'h03;
  localparam logic [7:0] CMD_REPROGRAM    = 8'h05;
  localparam logic [7:0] CMD_STEP         = 8'h06;

  // Clocks per oversample tick, integer floor.
  function automatic int baud_divisor(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clk s_tick every DIVISOR clocks.
module uart_baud_gen #(
  parameter int DIVISOR = 162
) (
  input  logic clk,
  input  logic reset,
  output logic s_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s_tick = (cnt_q == LAST);
    cnt_d  = s_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling; delivers each byte to the debug
// unit as a one-cycle rx_done_tick with rx_data, or flags a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 19200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output rx_state_e            dbg_state_o
);

  localparam int DIVISOR = baud_divisor(CLK_HZ, BAUD);
  localparam int NW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [3:0]    MID_START = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

  logic s_tick;

  uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick)
  );

  // Output strobes: rx_done_tick is a valid-only pulse with no ready; the
  // receiver never stalls, so the consumer samples rx_data in the pulse cycle
  // (it stays stable until the next good frame). frame_err is a separate
  // one-cycle pulse and never coincides with rx_done_tick.
  logic                 sync1_q, rx_sync;
  rx_state_e            state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= RX_IDLE;
      s_cnt_q <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_sync <= sync1_q;
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        // Start edge is taken immediately, not on a tick.
        if (!rx_sync) begin
          state_d = RX_START;
          s_cnt_d = '0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_START) begin
            if (!rx_sync) begin
              state_d = RX_DATA;
              s_cnt_d = '0;
              n_d     = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shreg_d = {rx_sync, shreg_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) state_d = RX_STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            state_d = RX_IDLE;
            s_cnt_d = '0;
            if (rx_sync) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign rx_data      = data_q;
  assign dbg_state_o  = state_q;

endmodule
